// File: rtl/game_master_multi_fsm.sv
// Round controller for the multi-target torpedo game: sequences target/torpedo
// sprites, tracks kills and shots, and hands off to the end-of-game timer.
module game_master_multi_fsm #(
  parameter int N_TARGETS = 4,
  parameter int N_SHOTS   = 3,
  parameter int SCORE_W   = 8,
  localparam int SHOT_W   = $clog2(N_SHOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key,
  output logic [N_TARGETS-1:0] sprite_target_write_xy,
  output logic [N_TARGETS-1:0] sprite_target_write_dxy,
  output logic [N_TARGETS-1:0] sprite_target_enable_update,
  output logic                 sprite_torpedo_write_xy,
  output logic                 sprite_torpedo_write_dxy,
  output logic                 sprite_torpedo_enable_update,
  input  logic [N_TARGETS-1:0] sprite_target_within_screen,
  input  logic                 sprite_torpedo_within_screen,
  input  logic [N_TARGETS-1:0] collision,
  output logic                 end_of_game_timer_start,
  input  logic                 end_of_game_timer_running,
  output logic                 game_won,
  output logic [N_TARGETS-1:0] alive,
  output logic [SHOT_W-1:0]    shots_left,
  output logic [SCORE_W-1:0]   score
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_AIM    = 3'd1,
    ST_SHOOT  = 3'd2,
    ST_RELOAD = 3'd3,
    ST_END    = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  function automatic logic [4:0] popcount(input logic [N_TARGETS-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < N_TARGETS; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  state_t                 state, state_next;
  logic                   end_guard, end_guard_next;
  logic [N_TARGETS-1:0]   tgt_xy_next, tgt_dxy_next, tgt_en_next, alive_next;
  logic                   trp_xy_next, trp_dxy_next, trp_en_next;
  logic                   timer_start_next, won_next;
  logic [SHOT_W-1:0]      shots_next;
  logic [SCORE_W-1:0]     score_next;
  logic [SCORE_W+4:0]     score_sum;
  logic [N_TARGETS-1:0]   hit;
  logic                   escape, go_end, go_won;

  assign escape    = |(alive & ~sprite_target_within_screen);
  assign hit       = collision & alive;
  assign score_sum = {5'd0, score} + {{SCORE_W{1'b0}}, popcount(hit)};

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_next       = state;
    end_guard_next   = 1'b0;
    alive_next       = alive;
    shots_next       = shots_left;
    score_next       = score;
    won_next         = game_won;
    tgt_xy_next      = '0;
    tgt_dxy_next     = '0;
    trp_xy_next      = 1'b0;
    trp_dxy_next     = 1'b0;
    timer_start_next = 1'b0;
    go_end           = 1'b0;
    go_won           = 1'b0;
    case (state)
      ST_START: begin
        tgt_xy_next  = '1;
        tgt_dxy_next = '1;
        trp_xy_next  = 1'b1;
        alive_next   = '1;
        shots_next   = SHOT_W'(N_SHOTS);
        won_next     = 1'b0;
        state_next   = ST_AIM;
      end
      ST_AIM: begin
        if (escape) begin
          go_end = 1'b1;
        end else if (key && (shots_left != '0)) begin
          trp_dxy_next = 1'b1;
          shots_next   = shots_left - SHOT_W'(1);
          state_next   = ST_SHOOT;
        end else begin
          state_next = ST_AIM;
        end
      end
      ST_SHOOT: begin
        if (hit != '0) begin
          alive_next = alive & ~collision;
          score_next = (score_sum > {5'd0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        end else begin
          alive_next = alive;
        end
        // Kills recorded this cycle still count even if a target escapes.
        if (escape) begin
          go_end = 1'b1;
        end else if ((hit != '0) || !sprite_torpedo_within_screen) begin
          state_next = ST_RELOAD;
        end else begin
          state_next = ST_SHOOT;
        end
      end
      ST_RELOAD: begin
        trp_xy_next = 1'b1;
        if (alive == '0) begin
          go_end = 1'b1;
          go_won = 1'b1;
        end else if (shots_left == '0) begin
          go_end = 1'b1;
        end else begin
          state_next = ST_AIM;
        end
      end
      ST_END: begin
        if (!end_guard && !end_of_game_timer_running) state_next = ST_START;
        else state_next = ST_END;
      end
      default: state_next = ST_START;
    endcase
    if (go_end) begin
      state_next       = ST_END;
      timer_start_next = 1'b1;
      won_next         = go_won;
      end_guard_next   = 1'b1;
    end else begin
      won_next = won_next;
    end
    if ((state_next == ST_AIM) || (state_next == ST_SHOOT) || (state_next == ST_RELOAD))
      tgt_en_next = alive_next;
    else
      tgt_en_next = '0;
    trp_en_next = (state_next == ST_SHOOT);
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= ST_START;
      end_guard                    <= 1'b0;
      sprite_target_write_xy       <= '0;
      sprite_target_write_dxy      <= '0;
      sprite_target_enable_update  <= '0;
      sprite_torpedo_write_xy      <= 1'b0;
      sprite_torpedo_write_dxy     <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start      <= 1'b0;
      game_won                     <= 1'b0;
      alive                        <= '0;
      shots_left                   <= '0;
      score                        <= '0;
    end else begin
      state                        <= state_next;
      end_guard                    <= end_guard_next;
      sprite_target_write_xy       <= tgt_xy_next;
      sprite_target_write_dxy      <= tgt_dxy_next;
      sprite_target_enable_update  <= tgt_en_next;
      sprite_torpedo_write_xy      <= trp_xy_next;
      sprite_torpedo_write_dxy     <= trp_dxy_next;
      sprite_torpedo_enable_update <= trp_en_next;
      end_of_game_timer_start      <= timer_start_next;
      game_won                     <= won_next;
      alive                        <= alive_next;
      shots_left                   <= shots_next;
      score                        <= score_next;
    end
  end

endmodule

// File: doc/game_master_multi_fsm.md
# game_master_multi_fsm

Round controller for the torpedo game: N targets, limited torpedo magazine, per-target kill tracking and a cumulative score. It sits between the sprite engines (one per target plus one torpedo), the collision detectors and the end-of-game timer. It generalises the single-target master to N targets and multiple shots per round, and adds a reload phase.

## Interface
- N_TARGETS, default 4: number of target sprites (1..16).
- N_SHOTS, default 3: torpedoes per round (>=1).
- SCORE_W, default 8: score width.
- SHOT_W, derived: $clog2(N_SHOTS+1).

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- key  in  1  fire request, level, sampled each cycle.
- sprite_target_write_xy  out  N_TARGETS  per-target load start position, 1-cycle pulse.
- sprite_target_write_dxy  out  N_TARGETS  per-target load velocity, 1-cycle pulse.
- sprite_target_enable_update  out  N_TARGETS  per-target motion enable.
- sprite_torpedo_write_xy  out  1  load torpedo start position, pulse.
- sprite_torpedo_write_dxy  out  1  load torpedo velocity, pulse.
- sprite_torpedo_enable_update  out  1  torpedo motion enable.
- sprite_target_within_screen  in  N_TARGETS  per-target on-screen flag.
- sprite_torpedo_within_screen  in  1  torpedo on-screen flag.
- collision  in  N_TARGETS  torpedo-vs-target i overlap.
- end_of_game_timer_start  out  1  timer start pulse.
- end_of_game_timer_running  in  1  timer busy.
- game_won  out  1  result of the last round; held until the next START.
- alive  out  N_TARGETS  targets not yet destroyed this round.
- shots_left  out  SHOT_W  remaining torpedoes.
- score  out  SCORE_W  cumulative kills, saturating.

## Operation
- All outputs are registered: the next-state logic is computed combinationally and lands on the next clk edge.
- States: START, AIM, SHOOT, RELOAD, END.
- escape = |(alive & ~sprite_target_within_screen).
- hit = collision & alive.
- START (1 cycle):
  - Pulse all target write_xy and write_dxy, plus torpedo write_xy.
  - alive <= all ones; shots_left <= N_SHOTS; game_won <= 0.
  - Next state AIM.
- AIM:
  - target_enable_update = alive; torpedo frozen.
  - If escape: go to END, lost.
  - Else if key and shots_left != 0: pulse torpedo write_dxy, shots_left--, go to SHOOT.
- SHOOT:
  - target_enable_update = alive; torpedo_enable_update = 1.
  - If hit != 0:
    - alive <= alive & ~collision.
    - score += popcount(hit), saturating at 2^SCORE_W-1.
  - Priority: escape → END lost (kills this cycle still recorded); else hit != 0 or !torpedo_within_screen → RELOAD; else stay.
- RELOAD (1 cycle):
  - Pulse torpedo write_xy; targets keep moving; collision ignored.
  - If alive == 0: END won.
  - Else if shots_left == 0: END lost.
  - Else AIM.
- END:
  - The transition into END pulses end_of_game_timer_start and sets game_won (1 won / 0 lost).
  - All enables are 0.
  - The first cycle in END is a guard cycle: timer_running is ignored.
  - From the second cycle on, !end_of_game_timer_running → START.
- collision is honoured only in SHOOT. Lingering overlap in RELOAD or AIM, before the torpedo is repositioned, must not kill or score.
- key while in SHOOT, RELOAD or END is ignored; no queuing.
- A new round clears alive and shots_left. score is cleared only by reset.

## Timing
- Reset values: state START, every output 0 (alive = 0, shots_left = 0, score = 0, game_won = 0).
- First clk after reset release: START outputs asserted one cycle later.
- Latency:
  - Input sampled in cycle t → corresponding output and state in cycle t+1.
  - key in AIM → torpedo_write_dxy and torpedo_enable_update first high at t+1.
- Write pulses are exactly one cycle wide.
- end_of_game_timer_start is one cycle wide per round.
- Minimum END duration is 2 cycles, even if the timer never asserts running.
- Reset mid-round: immediate return to the reset values; no END pulse is issued.

## Test plan
- Reset, N_TARGETS=4, N_SHOTS=3, all on-screen, no key for 20 cycles → alive=4'b1111, shots_left=3, state AIM, target_enable_update=4'b1111, torpedo enable 0.
- key 1 cycle; 5 cycles later collision=4'b0100 for 3 cycles → alive=4'b1011, score=1, shots_left=2, one torpedo_write_xy pulse, no second increment.
- Three shots, each leaving the screen without a hit → after the third RELOAD: END, game_won=0, timer_start single pulse, score unchanged.
- Kill all four targets (include one shot with collision=4'b0011) → score +4, game_won=1 on END entry; timer_running held 10 cycles then low → START 1 cycle after it drops.
- In SHOOT, collision=4'b0001 and target 2 off-screen in the same cycle → alive bit 0 cleared, score+1, END lost.
- SCORE_W=2: four kills across rounds → score saturates at 3. Assert reset during SHOOT → all outputs 0 asynchronously, no timer_start.
